i2s_tx2: RTL and testbench

- I2S master transmitter; the stage directly upstream of the I2S receiver.
- Accepts stereo sample pairs over a valid/ready handshake and buffers one pair.
- Generates ws and serialises sd MSB-first, in Philips I2S format with a one-bit delay.
- Drives a slave receiver with an identical chan0/chan1 convention (chan0 = left, sent while ws=0).

---
 rtl/i2s_tx2.sv | 79 +++++++
 tb/tb_i2s_tx2.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/i2s_tx2.sv
// i2s_tx2: I2S master transmitter, Philips format, with a one-pair holding buffer
module i2s_tx2 #(
   parameter int word_size = 32,
   parameter int slot_bits = 32
) (
   input  logic                 sck,
   input  logic                 nrst,
   input  logic                 enable,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [word_size-1:0] in_chan0,
   input  logic [word_size-1:0] in_chan1,
   output logic                 ws,
   output logic                 sd,
   output logic                 underrun
);
   localparam int fw = 2 * slot_bits;
   localparam int cw = $clog2(fw);
   localparam int ew = word_size + slot_bits;
   localparam logic [0:0] st_idle = 1'b0;
   localparam logic [0:0] st_run = 1'b1;
   localparam logic [cw-1:0] half = cw'(slot_bits);
   localparam logic [cw-1:0] last = cw'(fw - 1);
   logic [0:0] state;
   logic [cw-1:0] cnt;
   logic hold_full;
   logic [2*word_size-1:0] hold;
   logic [fw-1:0] shifter;
   logic lag;
   logic [ew-1:0] ext0, ext1;
   logic [fw-1:0] frame;
   logic boundary, load, ws_int;
   assign in_ready = !hold_full;
   assign boundary = state == st_run && cnt == last;
   assign load = enable && hold_full && (state == st_idle || boundary);
   assign underrun = boundary && enable && !hold_full;
   assign ws_int = state == st_idle || cnt >= half;
   // Zero-extend each word below its MSB, then keep the top slot_bits: truncates or pads as needed
   assign ext0 = {hold[2*word_size-1:word_size], {slot_bits{1'b0}}};
   assign ext1 = {hold[word_size-1:0], {slot_bits{1'b0}}};
   assign frame = {slot_bits'(ext0 >> word_size), slot_bits'(ext1 >> word_size)};
   always_ff @(posedge sck or negedge nrst)
      if (!nrst) begin
         state <= st_idle;
         cnt <= '0;
         hold_full <= 1'b0;
         hold <= '0;
         shifter <= '0;
         lag <= 1'b0;
      end else begin
         if (in_valid && !hold_full) begin
            hold_full <= 1'b1;
            hold <= {in_chan0, in_chan1};
         end else if (load)
            hold_full <= 1'b0;
         if (state == st_idle) begin
            lag <= 1'b0;
            if (load) begin
               state <= st_run;
               cnt <= '0;
               shifter <= frame;
            end
         end else begin
            // lag delays data one bit behind ws, giving the Philips one-bit offset
            lag <= shifter[fw-1];
            cnt <= boundary ? '0 : cnt + 1'b1;
            if (boundary && !enable) state <= st_idle;
            shifter <= (boundary && enable) ? (hold_full ? frame : '0) : shifter << 1;
         end
      end
   always_ff @(negedge sck or negedge nrst)
      if (!nrst) begin
         ws <= 1'b1;
         sd <= 1'b0;
      end else begin
         ws <= ws_int;
         sd <= lag;
      end
endmodule

// File: tb/tb_i2s_tx2.sv
// tb_i2s_tx2: randomized bench; a behavioural I2S receiver decodes ws/sd traces of three slot sizes
module tb_i2s_tx2;
   logic sck = 1'b0, nrst = 1'b1, enable = 1'b0;
   logic [2:0] valid = '0;
   logic [31:0] c0 = '0, c1 = '0;
   logic [2:0] rdy, wsv, sdv, und;
   logic [2:0] tr0[$], tr1[$], tr2[$];
   int checks = 0, errors = 0, und_cnt = 0, rises = 0;
   logic prev_rdy = 1'b1;
   always #5 sck = ~sck;
   i2s_tx2 #(.word_size(32), .slot_bits(32)) dut32 (.sck(sck), .nrst(nrst), .enable(enable), .in_valid(valid[0]), .in_ready(rdy[0]), .in_chan0(c0), .in_chan1(c1), .ws(wsv[0]), .sd(sdv[0]), .underrun(und[0]));
   i2s_tx2 #(.word_size(32), .slot_bits(20)) dut20 (.sck(sck), .nrst(nrst), .enable(enable), .in_valid(valid[1]), .in_ready(rdy[1]), .in_chan0(c0), .in_chan1(c1), .ws(wsv[1]), .sd(sdv[1]), .underrun(und[1]));
   i2s_tx2 #(.word_size(32), .slot_bits(40)) dut40 (.sck(sck), .nrst(nrst), .enable(enable), .in_valid(valid[2]), .in_ready(rdy[2]), .in_chan0(c0), .in_chan1(c1), .ws(wsv[2]), .sd(sdv[2]), .underrun(und[2]));
   always @(posedge sck) begin
      tr0.push_back({und[0], wsv[0], sdv[0]});
      tr1.push_back({und[1], wsv[1], sdv[1]});
      tr2.push_back({und[2], wsv[2], sdv[2]});
      if (und[0]) und_cnt++;
      if (rdy[0] && !prev_rdy) rises++;
      prev_rdy = rdy[0];
   end
   function automatic logic [31:0] expw(input logic [31:0] w, input int s);
      return s >= 32 ? w : w & ~(32'hFFFF_FFFF >> s);
   endfunction
   task automatic cyc(input int n);
      repeat (n) @(negedge sck);
   endtask
   task automatic send(input int d, input logic [31:0] a, input logic [31:0] b);
      int n = 0;
      @(negedge sck);
      c0 = a;
      c1 = b;
      valid[d] = 1'b1;
      while (!rdy[d] && n < 1000) begin
         @(negedge sck);
         n++;
      end
      checks++;
      if (!rdy[d]) begin errors++; $display("FAIL send_timeout dut%0d: in_ready=%b required 1", d, rdy[d]); end
      @(posedge sck);
      #1 valid[d] = 1'b0;
   endtask
   task automatic wait_ready(input int d);
      int n = 0;
      while (!rdy[d] && n < 1000) begin
         @(negedge sck);
         n++;
      end
      checks++;
      if (!rdy[d]) begin errors++; $display("FAIL ready_timeout dut%0d: in_ready=%b required 1", d, rdy[d]); end
   endtask
   // Receiver: a frame starts at each ws 1->0; slot bit b sits one cycle after its ws position
   task automatic decode(input int s, input logic [2:0] tr[$], output logic [63:0] fr[$], output int st[$], output int bad, output int und_at);
      logic [31:0] l, r;
      fr.delete();
      st.delete();
      bad = 0;
      und_at = -1;
      for (int t = 0; t < tr.size(); t++) if (tr[t][2] && und_at < 0) und_at = t;
      for (int t = 1; t + 2 * s < tr.size(); t++)
         if (tr[t-1][1] && !tr[t][1]) begin
            l = '0;
            r = '0;
            for (int b = 0; b < s; b++) begin
               if (tr[t+b][1] !== 1'b0 || tr[t+s+b][1] !== 1'b1) bad++;
               if (b < 32) begin
                  l[31-b] = tr[t+1+b][0];
                  r[31-b] = tr[t+s+1+b][0];
               end else bad += int'(tr[t+1+b][0]) + int'(tr[t+s+1+b][0]);
            end
            fr.push_back({l, r});
            st.push_back(t);
         end
   endtask
   task automatic test_reset;
      nrst = 1'b1;
      #2 nrst = 1'b0;
      #1;
      checks++; if (wsv[0] !== 1'b1) begin errors++; $display("FAIL reset_ws: got %b expected 1", wsv[0]); end
      checks++; if (sdv[0] !== 1'b0) begin errors++; $display("FAIL reset_sd: got %b expected 0", sdv[0]); end
      checks++; if (rdy[0] !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", rdy[0]); end
      checks++; if (und[0] !== 1'b0) begin errors++; $display("FAIL reset_underrun: got %b expected 0", und[0]); end
      cyc(3);
      nrst = 1'b1;
      cyc(3);
      #1;
      checks++; if ({wsv, sdv} !== 6'b111_000) begin errors++; $display("FAIL idle_outputs: ws=%b sd=%b expected ws=111 sd=000", wsv, sdv); end
   endtask
   task automatic test_single;
      logic [63:0] fr[$];
      int st[$], bad, ua;
      enable = 1'b1;
      @(negedge sck);
      tr0.delete();
      c0 = 32'hA5A5_0F0F;
      c1 = 32'h1234_5678;
      valid[0] = 1'b1;
      @(posedge sck);
      #1 valid[0] = 1'b0;
      @(posedge sck);
      #1;
      checks++; if (wsv[0] !== 1'b1) begin errors++; $display("FAIL latency_ws_hold: got %b expected 1", wsv[0]); end
      @(negedge sck);
      #1;
      checks++; if (wsv[0] !== 1'b0) begin errors++; $display("FAIL latency_ws_fall: got %b expected 0", wsv[0]); end
      @(negedge sck);
      #1;
      checks++; if (sdv[0] !== 1'b1) begin errors++; $display("FAIL latency_left_msb: got %b expected 1", sdv[0]); end
      cyc(70);
      enable = 1'b0;
      cyc(150);
      decode(32, tr0, fr, st, bad, ua);
      checks++; if (fr.size() != 2) begin errors++; $display("FAIL single_frames: got %0d expected 2", fr.size()); end
      checks++; if (fr.size() > 0 && fr[0] !== 64'hA5A5_0F0F_1234_5678) begin errors++; $display("FAIL single_pair: got %h expected a5a50f0f12345678", fr[0]); end
      checks++; if (fr.size() > 1 && fr[1] !== 64'h0) begin errors++; $display("FAIL single_zero_frame: got %h expected 0", fr[1]); end
      checks++; if (bad != 0) begin errors++; $display("FAIL single_ws_pattern: %0d bad bits expected 0", bad); end
   endtask
   task automatic test_back_to_back;
      logic [63:0] fr[$], exp[$], p;
      int st[$], bad, ua;
      @(negedge sck);
      tr0.delete();
      und_cnt = 0;
      rises = 0;
      enable = 1'b1;
      for (int i = 0; i < 200; i++) begin
         p = {$urandom, $urandom};
         exp.push_back(p);
         send(0, p[63:32], p[31:0]);
      end
      wait_ready(0);
      enable = 1'b0;
      cyc(160);
      decode(32, tr0, fr, st, bad, ua);
      checks++; if (fr.size() != 200) begin errors++; $display("FAIL b2b_frames: got %0d expected 200", fr.size()); end
      for (int i = 0; i < 200 && i < fr.size(); i++) begin
         checks++; if (fr[i] !== exp[i]) begin errors++; $display("FAIL b2b_pair%0d: got %h expected %h", i, fr[i], exp[i]); end
      end
      checks++; if (und_cnt != 0) begin errors++; $display("FAIL b2b_underrun: got %0d pulses expected 0", und_cnt); end
      checks++; if (rises != 200) begin errors++; $display("FAIL b2b_ready_pulses: got %0d expected 200", rises); end
      checks++; if (bad != 0) begin errors++; $display("FAIL b2b_ws_pattern: %0d bad bits expected 0", bad); end
   endtask
   task automatic test_starve;
      logic [63:0] fr[$], exp[$], p;
      int st[$], bad, ua, n;
      @(negedge sck);
      tr0.delete();
      und_cnt = 0;
      enable = 1'b1;
      for (int i = 0; i < 2; i++) begin
         p = {$urandom, $urandom};
         exp.push_back(p);
         send(0, p[63:32], p[31:0]);
      end
      exp.push_back(64'h0);
      n = 0;
      while (und_cnt == 0 && n < 400) begin
         @(negedge sck);
         n++;
      end
      checks++; if (und_cnt != 1) begin errors++; $display("FAIL starve_wait_underrun: got %0d pulses expected 1", und_cnt); end
      p = {$urandom, $urandom};
      exp.push_back(p);
      send(0, p[63:32], p[31:0]);
      wait_ready(0);
      enable = 1'b0;
      cyc(160);
      decode(32, tr0, fr, st, bad, ua);
      checks++; if (fr.size() != 4) begin errors++; $display("FAIL starve_frames: got %0d expected 4", fr.size()); end
      for (int i = 0; i < 4 && i < fr.size(); i++) begin
         checks++; if (fr[i] !== exp[i]) begin errors++; $display("FAIL starve_frame%0d: got %h expected %h", i, fr[i], exp[i]); end
      end
      checks++; if (und_cnt != 1) begin errors++; $display("FAIL starve_underrun_count: got %0d expected 1", und_cnt); end
      checks++; if (st.size() < 3 || ua != st[2] - 1) begin errors++; $display("FAIL starve_underrun_cycle: got index %0d expected last cycle before zero frame", ua); end
   endtask
   task automatic test_slot(input int d, input int s);
      logic [63:0] fr[$], exp[$], p;
      int st[$], bad, ua;
      @(negedge sck);
      if (d == 1) tr1.delete(); else tr2.delete();
      enable = 1'b1;
      for (int i = 0; i < 3; i++) begin
         p = (i == 0) ? 64'hFFFF_FFFF_FFFF_FFFF : {$urandom, $urandom};
         exp.push_back({expw(p[63:32], s), expw(p[31:0], s)});
         send(d, p[63:32], p[31:0]);
      end
      wait_ready(d);
      enable = 1'b0;
      cyc(4 * s + 20);
      if (d == 1) decode(s, tr1, fr, st, bad, ua); else decode(s, tr2, fr, st, bad, ua);
      checks++; if (fr.size() != 3) begin errors++; $display("FAIL slot%0d_frames: got %0d expected 3", s, fr.size()); end
      for (int i = 0; i < 3 && i < fr.size(); i++) begin
         checks++; if (fr[i] !== exp[i]) begin errors++; $display("FAIL slot%0d_pair%0d: got %h expected %h", s, i, fr[i], exp[i]); end
      end
      checks++; if (st.size() < 2 || st[1] - st[0] != 2 * s) begin errors++; $display("FAIL slot%0d_period: got %0d expected %0d", s, st.size() < 2 ? -1 : st[1] - st[0], 2 * s); end
      checks++; if (bad != 0) begin errors++; $display("FAIL slot%0d_pattern: %0d bad bits expected 0", s, bad); end
   endtask
   task automatic test_enable_drop;
      logic [63:0] fr[$];
      int st[$], bad, ua;
      @(negedge sck);
      tr0.delete();
      enable = 1'b1;
      send(0, 32'hFFFF_FFFF, 32'h0F0F_0F0F);
      cyc(10);
      enable = 1'b0;
      cyc(100);
      #1;
      decode(32, tr0, fr, st, bad, ua);
      checks++; if (fr.size() != 1 || fr[0] !== 64'hFFFF_FFFF_0F0F_0F0F) begin errors++; $display("FAIL drop_frame: got %0d frames first %h expected 1 frame ffffffff0f0f0f0f", fr.size(), fr.size() > 0 ? fr[0] : 64'h0); end
      checks++; if (wsv[0] !== 1'b1 || sdv[0] !== 1'b0) begin errors++; $display("FAIL drop_idle: ws=%b sd=%b expected ws=1 sd=0", wsv[0], sdv[0]); end
   endtask
   task automatic test_async_reset;
      enable = 1'b1;
      send(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      cyc(15);
      send(0, 32'h1111_1111, 32'h2222_2222);
      #1;
      checks++; if (wsv[0] !== 1'b0 || sdv[0] !== 1'b1 || rdy[0] !== 1'b0) begin errors++; $display("FAIL pre_reset: ws=%b sd=%b ready=%b expected 0 1 0", wsv[0], sdv[0], rdy[0]); end
      nrst = 1'b0;
      #1;
      checks++; if (wsv[0] !== 1'b1) begin errors++; $display("FAIL async_ws: got %b expected 1", wsv[0]); end
      checks++; if (sdv[0] !== 1'b0) begin errors++; $display("FAIL async_sd: got %b expected 0", sdv[0]); end
      checks++; if (rdy[0] !== 1'b1) begin errors++; $display("FAIL async_ready: got %b expected 1", rdy[0]); end
      checks++; if (und[0] !== 1'b0) begin errors++; $display("FAIL async_underrun: got %b expected 0", und[0]); end
      @(negedge sck);
      nrst = 1'b1;
      enable = 1'b0;
      cyc(2);
   endtask
   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end
   initial begin
      test_reset;
      test_single;
      test_back_to_back;
      test_starve;
      test_slot(1, 20);
      test_slot(2, 40);
      test_enable_drop;
      test_async_reset;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
